// File: rtl/sample_framer_pkg.sv
// sample_framer_pkg: state encoding and header field layout shared with downstream consumers
package sample_framer_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_FEAT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        HDR  = ST_HDR,
        FEAT = ST_FEAT,
        DONE = ST_DONE
    } state_t;
    localparam int IDX_MSB   = 31;
    localparam int IDX_LSB   = 16;
    localparam int LABEL_MSB = 7;
    // Header word: sample index in the top half, label in the low byte, zero between
    function automatic logic [31:0] make_header(input logic [15:0] idx, input logic [7:0] label);
        logic [31:0] h;
        h = '0;
        h[IDX_MSB:IDX_LSB] = idx;
        h[LABEL_MSB:0] = label;
        return h;
    endfunction
endpackage

// File: rtl/sample_framer.sv
// sample_framer: prefixes each block of feature words with an index/label header, frame by frame
module sample_framer
    import sample_framer_pkg::*;
#(
    parameter int FEATURE_WORDS = 512,
    parameter int NUM_SAMPLES   = 4500
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [31:0] Input_1_V_TDATA,
    input  logic        Input_1_V_TVALID,
    output logic        Input_1_V_TREADY,
    input  logic [31:0] Input_2_V_TDATA,
    input  logic        Input_2_V_TVALID,
    output logic        Input_2_V_TREADY,
    output logic [31:0] Output_1_V_TDATA,
    output logic        Output_1_V_TVALID,
    input  logic        Output_1_V_TREADY
);
    localparam int CW = (FEATURE_WORDS > 1) ? $clog2(FEATURE_WORDS) : 1;

    state_t        state, state_nxt;
    logic [15:0]   sample_idx;
    logic [CW-1:0] word_cnt;
    logic          out_vld;
    logic [31:0]   out_data;
    logic          can_load, hdr_fire, feat_fire, last_word, last_sample, done_fire;
    logic          unused_label_hi;

    assign unused_label_hi = ^Input_2_V_TDATA[31:8];
    assign can_load    = !out_vld || Output_1_V_TREADY;
    assign last_word   = word_cnt == CW'(FEATURE_WORDS - 1);
    assign last_sample = sample_idx == 16'(NUM_SAMPLES - 1);
    assign hdr_fire    = Input_2_V_TREADY && Input_2_V_TVALID;
    assign feat_fire   = Input_1_V_TREADY && Input_1_V_TVALID;

    // Outputs are forced to their idle values while reset is held, even before the first edge
    assign Input_2_V_TREADY  = ap_rst_n && state == HDR && can_load;
    assign Input_1_V_TREADY  = ap_rst_n && state == FEAT && can_load;
    assign Output_1_V_TVALID = ap_rst_n && out_vld;
    assign Output_1_V_TDATA  = ap_rst_n ? out_data : 32'h0;
    assign ap_done           = ap_rst_n && done_fire;
    assign ap_ready          = ap_done;
    assign ap_idle           = !ap_rst_n || (state == IDLE && !out_vld);

    // State register
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next state; the frame finishes only once the last word has left the output register
    always_comb begin
        state_nxt = state;
        done_fire = 1'b0;
        case (state)
            IDLE: state_nxt = ap_start ? HDR : IDLE;
            HDR:  state_nxt = hdr_fire ? FEAT : HDR;
            FEAT: if (feat_fire && last_word) state_nxt = last_sample ? DONE : HDR;
            DONE: if (!out_vld) begin
                done_fire = 1'b1;
                state_nxt = ap_start ? HDR : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register, word counter and sample index
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            out_vld    <= 1'b0;
            out_data   <= '0;
            word_cnt   <= '0;
            sample_idx <= '0;
        end else begin
            if (hdr_fire) begin
                out_vld  <= 1'b1;
                out_data <= make_header(sample_idx, Input_2_V_TDATA[7:0]);
            end else if (feat_fire) begin
                out_vld  <= 1'b1;
                out_data <= Input_1_V_TDATA;
            end else if (Output_1_V_TREADY) begin
                out_vld  <= 1'b0;
            end
            if (feat_fire) begin
                word_cnt <= last_word ? '0 : word_cnt + 1'b1;
                if (last_word && !last_sample) sample_idx <= sample_idx + 16'd1;
            end
            if (done_fire) sample_idx <= '0;
        end
    end
endmodule
